// File: rtl/sram_stream_reader_if.sv
// SRAM read port plus valid/ready stream bundle used by sram_stream_reader.
// The master modport is the reader's side of both buses.
interface sram_stream_reader_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 73
);
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_din;
  logic [DATA_W-1:0] sram_dout;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  modport master (
    output sram_we, sram_addr, sram_din, m_valid, m_data, m_last,
    input  sram_dout, m_ready
  );

  modport slave (
    input  sram_we, sram_addr, sram_din, m_valid, m_data, m_last,
    output sram_dout, m_ready
  );
endinterface

// File: rtl/sram_stream_reader.sv
// Sequential SRAM reader that streams length words from base_addr over valid/ready.
// Optional macro SRAM_READER_STALL_CNT_EN adds a saturating stall_cnt output.
module sram_stream_reader #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 73,
  parameter int WORDS      = 50176,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sram_stream_reader_if.master bus,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [LEN_W-1:0]     length,
  output logic                 busy,
  output logic                 done
`ifdef SRAM_READER_STALL_CNT_EN
  ,
  output logic [31:0]          stall_cnt
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_next;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_issued;
  logic [LEN_W-1:0]  r_beat;
  logic [1:0]        r_pend;
  logic              r_busy;
  logic              r_done;
  logic [DATA_W-1:0] r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;

  logic [1:0]        w_pend_cnt;
  logic [CNT_W:0]    w_occ;
  logic              w_issue_ok;
  logic              w_issue;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_valid;
  logic              w_last_beat;

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(WORDS - 1)) ? '0 : a + ADDR_W'(1);
  endfunction

  // Reads in flight are credited against FIFO space so a push always has room.
  assign w_pend_cnt  = {1'b0, r_pend[0]} + {1'b0, r_pend[1]};
  assign w_occ       = {1'b0, r_count} + {{(CNT_W-1){1'b0}}, w_pend_cnt};
  assign w_issue_ok  = w_occ < (CNT_W+1)'(FIFO_DEPTH);
  assign w_issue     = (r_state == ISSUE) && w_issue_ok;
  assign w_accept    = (r_state == IDLE) && start && (length != '0);
  assign w_push      = r_pend[1];
  assign w_valid     = (r_count != '0);
  assign w_pop       = w_valid && bus.m_ready;
  assign w_last_beat = (r_beat == r_len - LEN_W'(1));

  // Stage p0: address issue and FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_next   <= '0;
      r_len    <= '0;
      r_issued <= '0;
      r_pend   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_pend <= {r_pend[0], w_issue};
      case (r_state)
        IDLE: begin
          if (start) begin
            if (length != '0) begin
              r_next   <= base_addr;
              r_len    <= length;
              r_issued <= '0;
              r_busy   <= 1'b1;
              r_state  <= ISSUE;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (w_issue_ok) begin
            r_addr   <= r_next;
            r_next   <= next_addr(r_next);
            r_issued <= r_issued + LEN_W'(1);
            if (r_issued == r_len - LEN_W'(1)) r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_pop && w_last_beat) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Stage p2: SRAM data capture into the output FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_beat  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_accept)   r_beat <= '0;
      else if (w_pop) r_beat <= r_beat + LEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= bus.sram_dout;
  end

`ifdef SRAM_READER_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                r_stall_cnt <= '0;
    else if (w_accept)                         r_stall_cnt <= '0;
    else if (r_busy && w_valid && !bus.m_ready) r_stall_cnt <= sat_inc32(r_stall_cnt);
  end

  assign stall_cnt = r_stall_cnt;
`endif

  // Head is masked so a freshly reset FIFO never exposes stale RAM contents.
  assign bus.sram_we   = 1'b0;
  assign bus.sram_din  = '0;
  assign bus.sram_addr = r_addr;
  assign bus.m_valid   = w_valid;
  assign bus.m_data    = w_valid ? r_fifo[r_rptr] : '0;
  assign bus.m_last    = w_valid && w_last_beat;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule

// File: tb/tb_sram_stream_reader.sv
// Scoreboard bench for sram_stream_reader: jobs push expected beats, a monitor pops and compares.
module tb_sram_stream_reader;

  typedef struct {
    logic [72:0] d;
    logic        l;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] length;
  logic        busy;
  logic        done;
`ifdef SRAM_READER_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  sram_stream_reader_if #(.ADDR_W(16), .DATA_W(73)) bus ();

  sram_stream_reader #(
    .ADDR_W(16), .DATA_W(73), .WORDS(50176), .LEN_W(16), .FIFO_DEPTH(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done)
`ifdef SRAM_READER_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [72:0] word(input logic [15:0] a);
    return {a[8:0] ^ 9'h155, 16'hC0DE, a, 16'(a * 16'd7 + 16'd3), a ^ 16'hFFFF};
  endfunction

  // SRAM model: one-cycle registered read
  always @(posedge clk) bus.sram_dout <= word(bus.sram_addr);

  beat_t q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    beats_seen = 0;
  int    stalls = 0;
  int    done_cnt = 0;
  int    exp_done = 0;
  int    we_bad = 0;
  logic        prev_stall = 1'b0;
  logic [72:0] held_d;
  logic        held_l;

  task automatic check(input string name, input logic [72:0] act, input logic [72:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", {72'd0, bus.m_valid}, 73'd1);
        check("stall_data", bus.m_data, held_d);
        check("stall_last", {72'd0, bus.m_last}, {72'd0, held_l});
      end
      if (bus.m_valid && bus.m_ready) begin
        if (q.size() == 0) begin
          check("unexpected_beat", {72'd0, bus.m_valid}, 73'd0);
        end else begin
          beat_t e;
          e = q.pop_front();
          check("beat_data", bus.m_data, e.d);
          check("beat_last", {72'd0, bus.m_last}, {72'd0, e.l});
        end
        beats_seen++;
      end
      if (busy && bus.m_valid && !bus.m_ready) stalls++;
      prev_stall = bus.m_valid && !bus.m_ready;
      held_d = bus.m_data;
      held_l = bus.m_last;
      if (done) done_cnt++;
      if (bus.sram_we) we_bad++;
    end
  end

  task automatic start_job(input logic [15:0] b, input logic [15:0] l);
    logic [15:0] a;
    beat_t e;
    a = b;
    for (int i = 0; i < int'(l); i++) begin
      e.d = word(a);
      e.l = (i == int'(l) - 1);
      q.push_back(e);
      a = (a == 16'd50175) ? 16'd0 : a + 16'd1;
    end
    exp_done++;
    start = 1'b1;
    base_addr = b;
    length = l;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit toggle);
    bit got;
    got = 1'b0;
    for (int k = 0; k < budget && !got; k++) begin
      if (toggle) bus.m_ready = ((k % 4) == 0) || ((k % 4) == 3);
      tick();
      if (done) got = 1'b1;
    end
    check("done_seen", {72'd0, got}, 73'd1);
    bus.m_ready = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int b0;
    rst_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    length = '0;
    bus.m_ready = 1'b1;
    repeat (2) tick();
    check("rst_busy", {72'd0, busy}, 73'd0);
    check("rst_done", {72'd0, done}, 73'd0);
    check("rst_valid", {72'd0, bus.m_valid}, 73'd0);
    check("rst_addr", {57'd0, bus.sram_addr}, 73'd0);
    check("rst_data", bus.m_data, 73'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Job 1: base 10, length 4, sink always ready
    start_job(16'd10, 16'd4);
    check("t1_busy", {72'd0, busy}, 73'd1);
    check("t1_valid_s0", {72'd0, bus.m_valid}, 73'd0);
    tick();
    check("t1_addr0", {57'd0, bus.sram_addr}, 73'd10);
    check("t1_valid_s1", {72'd0, bus.m_valid}, 73'd0);
    tick();
    check("t1_addr1", {57'd0, bus.sram_addr}, 73'd11);
    check("t1_valid_s2", {72'd0, bus.m_valid}, 73'd0);
    tick();
    check("t1_addr2", {57'd0, bus.sram_addr}, 73'd12);
    check("t1_valid_s3", {72'd0, bus.m_valid}, 73'd1);
    check("t1_first_data", bus.m_data, word(16'd10));
    tick();
    check("t1_addr3", {57'd0, bus.sram_addr}, 73'd13);
    repeat (3) tick();
    check("t1_done", {72'd0, done}, 73'd1);
    check("t1_busy_fall", {72'd0, busy}, 73'd0);
    tick();
    check("t1_done_pulse", {72'd0, done}, 73'd0);
    check("t1_queue", 73'(q.size()), 73'd0);

    // Job 2: base 0, length 16, ready pattern 1,0,0,1
    stalls = 0;
    start_job(16'd0, 16'd16);
    wait_done(300, 1'b1);
    check("t2_queue", 73'(q.size()), 73'd0);
`ifdef SRAM_READER_STALL_CNT_EN
    check("t2_stall_cnt", {41'd0, stall_cnt}, 73'(stalls));
    tick();
    check("t2_stall_hold", {41'd0, stall_cnt}, 73'(stalls));
`else
    tick();
`endif

    // Job 3: zero length
    start_job(16'd7, 16'd0);
    check("t3_done", {72'd0, done}, 73'd1);
    check("t3_busy", {72'd0, busy}, 73'd0);
    check("t3_valid", {72'd0, bus.m_valid}, 73'd0);
    check("t3_addr", {57'd0, bus.sram_addr}, 73'd15);
    tick();
    check("t3_done_pulse", {72'd0, done}, 73'd0);
    check("t3_addr_hold", {57'd0, bus.sram_addr}, 73'd15);

    // Job 4: start while busy is ignored
    start_job(16'd100, 16'd6);
    tick();
    start = 1'b1;
    base_addr = 16'd500;
    length = 16'd3;
    tick();
    start = 1'b0;
    wait_done(50, 1'b0);
    repeat (5) tick();
    check("t4_busy", {72'd0, busy}, 73'd0);
    check("t4_valid", {72'd0, bus.m_valid}, 73'd0);
    check("t4_addr", {57'd0, bus.sram_addr}, 73'd105);
    check("t4_queue", 73'(q.size()), 73'd0);

    // Job 5: address wrap at WORDS-1
    start_job(16'd50174, 16'd4);
    tick();
    check("t5_addr0", {57'd0, bus.sram_addr}, 73'd50174);
    tick();
    check("t5_addr1", {57'd0, bus.sram_addr}, 73'd50175);
    tick();
    check("t5_addr2", {57'd0, bus.sram_addr}, 73'd0);
    tick();
    check("t5_addr3", {57'd0, bus.sram_addr}, 73'd1);
    wait_done(50, 1'b0);
    check("t5_queue", 73'(q.size()), 73'd0);

    // Job 6: reset after three beats, then a clean job
    start_job(16'd40, 16'd8);
    b0 = beats_seen;
    for (int k = 0; k < 50 && (beats_seen - b0) < 3; k++) tick();
    check("t6_three_beats", 73'(beats_seen - b0), 73'd3);
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", {72'd0, busy}, 73'd0);
    check("t6_rst_valid", {72'd0, bus.m_valid}, 73'd0);
    check("t6_rst_data", bus.m_data, 73'd0);
    check("t6_rst_last", {72'd0, bus.m_last}, 73'd0);
    check("t6_rst_addr", {57'd0, bus.sram_addr}, 73'd0);
    q.delete();
    exp_done--;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    start_job(16'd20, 16'd2);
    wait_done(50, 1'b0);
    repeat (5) tick();
    check("t6_queue", 73'(q.size()), 73'd0);
    check("t6_valid_idle", {72'd0, bus.m_valid}, 73'd0);

    check("done_count", 73'(done_cnt), 73'(exp_done));
    check("sram_we_low", 73'(we_bad), 73'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
